// File: rtl/muldiv_hilo_unit.sv
// Purpose: multi-cycle signed MULT/DIV engine with the architectural HI/LO pair and MFHI/MFLO read port.
// Latency: accept at edge 0, WIDTH iteration cycles, sign fixup commits HI/LO at edge WIDTH+1.
// Backpressure: stall holds IF/ID/EX from the cycle after accept through FIXUP; start is ignored while busy.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   start, alucontrol     EX holds a valid op; 1000 MULT, 1001 DIV, 1010 MFHI, 1011 MFLO
//   hien, loen            commit enables for HI / LO, latched at accept
//   srca, srcb            rs (multiplicand / dividend), rt (multiplier / divisor)
//   stall, done           busy indication; one-cycle pulse in the cycle HI/LO are written
//   divzero               sticky: last DIV had a zero divisor
//   mfresult              HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo                architectural HI/LO
module muldiv_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic             hien,
  input  logic             loen,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             stall,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] mfresult,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;
  localparam int         CW      = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN_MUL, RUN_DIV, FIXUP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;      // MULT: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
  logic [WIDTH-1:0]     opb;      // MULT: |multiplicand|; DIV: |divisor|
  logic [WIDTH-1:0]     a_raw;    // original srca, returned as HI on divide by zero
  logic                 rsign;
  logic                 asign;
  logic                 op_div;
  logic                 op_hien;
  logic                 op_loen;
  logic                 dz;

  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift, div_trial;
  logic [2*WIDTH-1:0]   mul_next, div_next, prod;
  logic [WIDTH-1:0]     hi_res, lo_res;

  assign accept    = start && (state == IDLE) && (alucontrol == OP_MULT || alucontrol == OP_DIV);
  assign last_iter = (cnt == CW'(WIDTH-1));

  // Unsigned magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag = srca[WIDTH-1] ? (~srca + 1'b1) : srca;
  assign b_mag = srcb[WIDTH-1] ? (~srcb + 1'b1) : srcb;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide: bring in the next dividend bit, keep the subtraction only if it did not borrow.
  // The remainder stays below the divisor, so a WIDTH+1-bit trial holds its sign in the top bit.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, opb};
  assign div_next  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  always_comb begin
    prod   = rsign ? -acc : acc;
    hi_res = prod[2*WIDTH-1:WIDTH];
    lo_res = prod[WIDTH-1:0];
    if (op_div) begin
      if (dz) begin
        hi_res = a_raw;
        lo_res = {WIDTH{1'b1}};
      end else begin
        lo_res = rsign ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        hi_res = asign ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (alucontrol == OP_DIV) ? RUN_DIV : RUN_MUL;
      end
      RUN_MUL, RUN_DIV: begin
        stall = 1'b1;
        if (last_iter) state_nxt = FIXUP;
      end
      FIXUP: begin
        stall     = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      a_raw   <= '0;
      rsign   <= 1'b0;
      asign   <= 1'b0;
      op_div  <= 1'b0;
      op_hien <= 1'b0;
      op_loen <= 1'b0;
      dz      <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      divzero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt     <= '0;
            a_raw   <= srca;
            rsign   <= srca[WIDTH-1] ^ srcb[WIDTH-1];
            asign   <= srca[WIDTH-1];
            op_div  <= (alucontrol == OP_DIV);
            op_hien <= hien;
            op_loen <= loen;
            dz      <= (srcb == '0);
            if (alucontrol == OP_DIV) begin
              acc <= {{WIDTH{1'b0}}, a_mag};
              opb <= b_mag;
            end else begin
              acc <= {{WIDTH{1'b0}}, b_mag};
              opb <= a_mag;
            end
          end
        end
        RUN_MUL: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
        end
        RUN_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
        end
        FIXUP: begin
          if (op_hien) hi <= hi_res;
          if (op_loen) lo <= lo_res;
          if (op_div)  divzero <= dz;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mfresult = '0;
    case (alucontrol)
      OP_MFHI: mfresult = hi;
      OP_MFLO: mfresult = lo;
      default: mfresult = '0;
    endcase
  end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Directed bench for muldiv_hilo_unit: hand-computed MULT/DIV results, latency, stall/done shape,
// divide-by-zero, overflow, ignored start under stall, mid-op reset and MFHI/MFLO reads.
module tb_muldiv_hilo_unit;

  localparam logic [3:0] MULT = 4'b1000;
  localparam logic [3:0] DIV  = 4'b1001;
  localparam logic [3:0] MFHI = 4'b1010;
  localparam logic [3:0] MFLO = 4'b1011;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [3:0]  alucontrol;
  logic        hien;
  logic        loen;
  logic [31:0] srca;
  logic [31:0] srcb;
  logic        stall;
  logic        done;
  logic        divzero;
  logic [31:0] mfresult;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec = 0;
  int n_err = 0;
  int sc, dc, da;

  muldiv_hilo_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alucontrol(alucontrol),
    .hien(hien), .loen(loen), .srca(srca), .srcb(srcb),
    .stall(stall), .done(done), .divzero(divzero), .mfresult(mfresult),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents the op for one rising edge (the accept edge).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic he, input logic le);
    start = 1'b1; alucontrol = op; srca = a; srcb = b; hien = he; loen = le;
    @(posedge clk);
    #1;
    start = 1'b0; alucontrol = 4'h0;
  endtask

  // Counts stalled cycles and done pulses; returns at the first negedge with stall low (bounded).
  task automatic run_wait(output int scnt, output int dcnt, output int dat);
    scnt = 0; dcnt = 0; dat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!stall) break;
      scnt++;
      if (done) begin
        dcnt++;
        dat = scnt;
      end
    end
  endtask

  task automatic op_run(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic he, input logic le);
    issue(op, a, b, he, le);
    run_wait(sc, dc, da);
    chk({tag, " stall cycles"}, sc, 33);
    chk({tag, " done pulses"}, dc, 1);
    chk({tag, " done in last stall cycle"}, da, 33);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; alucontrol = 4'h0; hien = 1'b0; loen = 1'b0;
    srca = '0; srcb = '0;
    repeat (2) @(negedge clk);
    chk("reset stall", stall, 0);
    chk("reset done", done, 0);
    chk("reset divzero", divzero, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 7 x -3 = -21
    op_run("mult 7x-3", MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1);
    chk("mult 7x-3 hi", hi, 32'hFFFF_FFFF);
    chk("mult 7x-3 lo", lo, 32'hFFFF_FFEB);
    chk("mult 7x-3 done after", done, 0);

    // 2: -7 / 2 = -3 rem -1
    op_run("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    chk("div -7/2 lo", lo, 32'hFFFF_FFFD);
    chk("div -7/2 hi", hi, 32'hFFFF_FFFF);
    chk("div -7/2 divzero", divzero, 0);

    // 3: divide by zero, then a clean divide clears the flag
    op_run("div 5/0", DIV, 32'd5, 32'd0, 1'b1, 1'b1);
    chk("div 5/0 hi", hi, 32'h0000_0005);
    chk("div 5/0 lo", lo, 32'hFFFF_FFFF);
    chk("div 5/0 divzero", divzero, 1);
    op_run("div 6/3", DIV, 32'd6, 32'd3, 1'b1, 1'b1);
    chk("div 6/3 lo", lo, 32'd2);
    chk("div 6/3 hi", hi, 32'd0);
    chk("div 6/3 divzero", divzero, 0);

    // 4: most-negative squared, then MF reads
    op_run("mult min*min", MULT, 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    chk("mult min*min hi", hi, 32'h4000_0000);
    chk("mult min*min lo", lo, 32'h0000_0000);
    alucontrol = MFHI; #1;
    chk("mfhi", mfresult, 32'h4000_0000);
    alucontrol = MFLO; #1;
    chk("mflo", mfresult, 32'h0000_0000);
    alucontrol = 4'b0010; #1;
    chk("mf other code", mfresult, 32'h0000_0000);
    alucontrol = 4'h0;
    @(negedge clk);

    // 5: overflow divide with a second start held during the stall
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    start = 1'b1; alucontrol = MULT; srca = 32'd3; srcb = 32'd3;
    run_wait(sc, dc, da);
    start = 1'b0; alucontrol = 4'h0;
    chk("div ovf stall cycles", sc, 33);
    chk("div ovf done pulses", dc, 1);
    chk("div ovf lo", lo, 32'h8000_0000);
    chk("div ovf hi", hi, 32'h0000_0000);
    dc = 0; sc = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) dc++;
      if (stall) sc++;
    end
    chk("div ovf no second op stall", sc, 0);
    chk("div ovf no second done", dc, 0);

    // 6: reset in the middle of a MULT
    issue(MULT, 32'h1234, 32'h5678, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    reset_n = 1'b0; #1;
    chk("abort stall", stall, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    chk("abort done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || stall) dc++;
    end
    chk("abort no late activity", dc, 0);
    op_run("mult 2x3", MULT, 32'd2, 32'd3, 1'b1, 1'b1);
    chk("mult 2x3 lo", lo, 32'd6);
    chk("mult 2x3 hi", hi, 32'd0);

    // No commit enables: runs and pulses done, HI/LO untouched
    op_run("mult nocommit", MULT, 32'd5, 32'd5, 1'b0, 1'b0);
    chk("mult nocommit lo", lo, 32'd6);
    chk("mult nocommit hi", hi, 32'd0);

    // LO-only commit of -20 / 3 = -6 rem -2
    op_run("div lo only", DIV, 32'hFFFF_FFEC, 32'd3, 1'b0, 1'b1);
    chk("div lo only lo", lo, 32'hFFFF_FFFA);
    chk("div lo only hi", hi, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
